// File: rtl/mcpu_control_unit.sv
// Multi-cycle CPU sequencing controller: instruction-phase FSM, datapath enables/selects,
// data-memory wait handshake and sticky halt.
module mcpu_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] State,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegOut,
  output logic       WrRegData,
  output logic       ALUM2Reg,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IF      = 3'b000,
    S_ID      = 3'b001,
    S_MEM_ADR = 3'b010,
    S_MEM     = 3'b011,
    S_WB_LW   = 3'b100,
    S_EXE_BEQ = 3'b101,
    S_EXE_ALU = 3'b110,
    S_WB_ALU  = 3'b111
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_halted;

  logic       w_is_alu;
  logic       w_is_beq;
  logic       w_is_sw;
  logic       w_is_lw;
  logic       w_is_jmp;
  logic       w_is_jr;
  logic       w_is_jal;
  logic       w_is_halt;
  logic       w_is_imm;
  logic [2:0] w_alu_op;

  // Opcode classification
  assign w_is_alu  = Opcode inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                    6'b010010, 6'b011000, 6'b100000, 6'b100111};
  assign w_is_beq  = (Opcode == 6'b110100);
  assign w_is_sw   = (Opcode == 6'b110000);
  assign w_is_lw   = (Opcode == 6'b110001);
  assign w_is_jmp  = Opcode inside {6'b111000, 6'b111001, 6'b111010};
  assign w_is_jr   = (Opcode == 6'b111001);
  assign w_is_jal  = (Opcode == 6'b111010);
  assign w_is_halt = (Opcode == 6'b111111);
  assign w_is_imm  = (Opcode == 6'b000010) || (Opcode == 6'b010010);

  always_comb begin
    w_alu_op = 3'b000;
    case (Opcode)
      6'b000001:            w_alu_op = 3'b001;
      6'b011000:            w_alu_op = 3'b010;
      6'b010000, 6'b010010: w_alu_op = 3'b011;
      6'b010001:            w_alu_op = 3'b100;
      6'b100111:            w_alu_op = 3'b101;
      default:              w_alu_op = 3'b000;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID && w_is_halt) r_halted <= 1'b1;
    end
  end

  // Next-state; a halted controller only ever bounces between IF and ID
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        if (r_halted)                w_next = S_IF;
        else if (w_is_alu)           w_next = S_EXE_ALU;
        else if (w_is_beq)           w_next = S_EXE_BEQ;
        else if (w_is_sw || w_is_lw) w_next = S_MEM_ADR;
        else                         w_next = S_IF;
      end
      S_EXE_ALU: w_next = S_WB_ALU;
      S_MEM_ADR: w_next = S_MEM;
      S_MEM: begin
        if (!mem_ready)   w_next = S_MEM;
        else if (w_is_lw) w_next = S_WB_LW;
        else              w_next = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    RegOut    = 2'b00;
    WrRegData = 1'b0;
    ALUM2Reg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    // Reset blanks every output, even the IF fetch strobes
    if (!Reset) begin
      case (r_state)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID: begin
          if (w_is_jmp) begin
            PCWre = 1'b1;
            PCSrc = w_is_jr ? 2'b10 : 2'b11;
            if (w_is_jal) RegWre = 1'b1;
          end else if (!w_is_alu && !w_is_beq && !w_is_sw && !w_is_lw && !w_is_halt) begin
            PCWre = 1'b1;
          end
        end
        S_EXE_ALU, S_WB_ALU: begin
          ALUOp   = w_alu_op;
          ALUSrcA = (Opcode == 6'b011000);
          ALUSrcB = w_is_imm;
          ExtSel  = (Opcode != 6'b010010);
          if (r_state == S_WB_ALU) begin
            RegWre    = 1'b1;
            WrRegData = 1'b1;
            RegOut    = w_is_imm ? 2'b01 : 2'b10;
            PCWre     = 1'b1;
          end
        end
        S_EXE_BEQ: begin
          ALUOp = 3'b001;
          PCWre = 1'b1;
          PCSrc = zero ? 2'b01 : 2'b00;
        end
        S_MEM_ADR: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
        end
        S_MEM: begin
          mRD   = w_is_lw;
          mWR   = w_is_sw;
          PCWre = w_is_sw && mem_ready;
        end
        S_WB_LW: begin
          RegWre    = 1'b1;
          WrRegData = 1'b1;
          ALUM2Reg  = 1'b1;
          RegOut    = 2'b01;
          PCWre     = 1'b1;
        end
        default: ;
      endcase
      if (r_halted) begin
        PCWre  = 1'b0;
        IRWre  = 1'b0;
        RegWre = 1'b0;
        mRD    = 1'b0;
        mWR    = 1'b0;
      end
    end
  end

  assign State  = r_state;
  assign halted = r_halted;

endmodule

// File: tb/tb_mcpu_control_unit.sv
// Bench for mcpu_control_unit: per-instruction phase-sequence model driven with random
// opcodes, zero flag and memory wait counts, plus literal spot checks of key traces.
module tb_mcpu_control_unit;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000, OP_MOVE = 6'b100000, OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110100, OP_SW   = 6'b110000, OP_LW   = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic       CLK, Reset, zero, mem_ready;
  logic [5:0] Opcode;
  logic [2:0] State, ALUOp;
  logic [1:0] RegOut, PCSrc;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegData, ALUM2Reg;
  logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, halted;

  mcpu_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero), .mem_ready(mem_ready),
    .State(State), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .RegOut(RegOut), .WrRegData(WrRegData), .ALUM2Reg(ALUM2Reg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .PCSrc(PCSrc), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {PH_IF, PH_ID, PH_EXA, PH_WBA, PH_BEQ, PH_MADR, PH_MEM, PH_WBLW} ph_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, insmem, regwre;
    logic [1:0] regout;
    logic       wrd, m2r, srca, srcb, ext;
    logic [2:0] aluop;
    logic       mrd, mwr;
    logic [1:0] pcsrc;
    logic       hlt;
  } exp_t;

  exp_t act, exp_r;
  assign act = {State, PCWre, IRWre, InsMemRW, RegWre, RegOut, WrRegData, ALUM2Reg,
                ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, PCSrc, halted};

  bit          exp_valid;
  bit          m_halted;
  int          n_vec, n_bad;
  logic [31:0] st_pack;
  int          n_cyc, pc_cnt, mrd_cnt, hold_cnt;
  logic [6:0]  id_snap;
  logic [1:0]  last_pcsrc;
  logic [3:0]  wb_snap;

  function automatic logic [2:0] code(ph_t p);
    case (p)
      PH_IF:   return 3'b000;
      PH_ID:   return 3'b001;
      PH_EXA:  return 3'b110;
      PH_WBA:  return 3'b111;
      PH_BEQ:  return 3'b101;
      PH_MADR: return 3'b010;
      PH_MEM:  return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  function automatic bit is_alu(logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_MOVE, OP_SLT};
  endfunction

  function automatic bit is_jmp(logic [5:0] op);
    return op inside {OP_J, OP_JR, OP_JAL};
  endfunction

  function automatic logic [2:0] alu_code(logic [5:0] op);
    case (op)
      OP_SUB:        return 3'd1;
      OP_SLL:        return 3'd2;
      OP_OR, OP_ORI: return 3'd3;
      OP_AND:        return 3'd4;
      OP_SLT:        return 3'd5;
      default:       return 3'd0;
    endcase
  endfunction

  // Expected outputs for one cycle of an instruction in phase p
  function automatic exp_t model(ph_t p, logic [5:0] op, logic z, logic mr, bit h);
    exp_t e;
    e     = '0;
    e.st  = code(p);
    e.hlt = h;
    case (p)
      PH_IF: begin e.insmem = 1'b1; e.irwre = 1'b1; end
      PH_ID: begin
        if (is_jmp(op)) begin
          e.pcwre  = 1'b1;
          e.pcsrc  = (op == OP_JR) ? 2'b10 : 2'b11;
          e.regwre = (op == OP_JAL);
        end else if (!is_alu(op) && !(op inside {OP_BEQ, OP_SW, OP_LW, OP_HALT})) begin
          e.pcwre = 1'b1;
        end
      end
      PH_EXA, PH_WBA: begin
        e.aluop = alu_code(op);
        e.srca  = (op == OP_SLL);
        e.srcb  = (op == OP_ADDI) || (op == OP_ORI);
        e.ext   = (op != OP_ORI);
        if (p == PH_WBA) begin
          e.regwre = 1'b1; e.wrd = 1'b1; e.pcwre = 1'b1;
          e.regout = e.srcb ? 2'b01 : 2'b10;
        end
      end
      PH_BEQ:  begin e.aluop = 3'd1; e.pcwre = 1'b1; e.pcsrc = z ? 2'b01 : 2'b00; end
      PH_MADR: begin e.srcb = 1'b1; e.ext = 1'b1; end
      PH_MEM: begin
        e.mrd   = (op == OP_LW);
        e.mwr   = (op == OP_SW);
        e.pcwre = (op == OP_SW) && mr;
      end
      default: begin
        e.regwre = 1'b1; e.wrd = 1'b1; e.m2r = 1'b1; e.regout = 2'b01; e.pcwre = 1'b1;
      end
    endcase
    if (h) begin e.pcwre = 1'b0; e.irwre = 1'b0; e.regwre = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; end
    return e;
  endfunction

  always @(negedge CLK) begin
    if (exp_valid) begin
      n_vec++;
      if (act !== exp_r) begin
        n_bad++;
        $display("FAIL outputs t=%0t op=%b state got %b exp %b, vector got %h exp %h",
                 $time, Opcode, act.st, exp_r.st, act, exp_r);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // One instruction; zf<0 randomizes zero, abort_at>=0 asserts Reset in that cycle
  task automatic run_instr(input logic [5:0] op, input int waits, input int zf, input int abort_at);
    ph_t seq[$];
    int  mk;
    seq = {PH_IF, PH_ID};
    if (!m_halted) begin
      if (is_alu(op)) begin
        seq.push_back(PH_EXA); seq.push_back(PH_WBA);
      end else if (op == OP_BEQ) begin
        seq.push_back(PH_BEQ);
      end else if (op == OP_SW || op == OP_LW) begin
        seq.push_back(PH_MADR);
        for (int k = 0; k <= waits; k++) seq.push_back(PH_MEM);
        if (op == OP_LW) seq.push_back(PH_WBLW);
      end
    end
    st_pack = '0; n_cyc = 0; pc_cnt = 0; mrd_cnt = 0; hold_cnt = 0; mk = 0;
    foreach (seq[i]) begin
      Opcode = op;
      zero   = (zf < 0) ? 1'($urandom) : 1'(zf);
      if (seq[i] == PH_MEM) begin
        mem_ready = (mk == waits);
        mk++;
      end else begin
        mem_ready = 1'($urandom);
      end
      exp_r     = model(seq[i], op, zero, mem_ready, m_halted);
      exp_valid = 1'b1;
      @(negedge CLK);
      st_pack   = (st_pack << 3) | 32'(State);
      n_cyc++;
      pc_cnt   += int'(PCWre);
      mrd_cnt  += int'(mRD);
      hold_cnt += int'(PCWre | IRWre);
      if (seq[i] == PH_ID) id_snap = {PCWre, RegWre, RegOut, WrRegData, PCSrc};
      last_pcsrc = PCSrc;
      wb_snap    = {RegWre, RegOut, ALUM2Reg};
      if (i == abort_at) begin
        #1;
        exp_valid = 1'b0;
        Reset     = 1'b1;
        #1;
        chk("abort_state", 32'(State), 32'd0);
        chk("abort_outs", 32'({PCWre, IRWre, InsMemRW, RegWre, mRD, mWR}), 32'd0);
        chk("abort_halted", 32'(halted), 32'd0);
        m_halted = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b0;
        return;
      end
      @(posedge CLK); #1;
      if (seq[i] == PH_ID && op == OP_HALT) m_halted = 1'b1;
    end
  endtask

  logic [5:0] ops [15];
  logic [5:0] rop;
  int         hold;

  function automatic logic [5:0] pick_op();
    logic [5:0] r;
    if ($urandom_range(0, 3) == 0) begin
      r = 6'($urandom);
      if (r == OP_HALT) r = 6'b000011;
    end else begin
      r = ops[$urandom_range(0, 14)];
    end
    return r;
  endfunction

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_MOVE, OP_SLT,
            OP_BEQ, OP_SW, OP_LW, OP_J, OP_JR, OP_JAL};
    Reset = 1'b1; Opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    exp_valid = 1'b0; m_halted = 1'b0; n_vec = 0; n_bad = 0;
    #12;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_outs", 32'({PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, halted}), 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;

    run_instr(OP_ADD, 0, -1, -1);
    chk("add_states", st_pack, 32'o0167);
    chk("add_pcwre_pulses", 32'(pc_cnt), 32'd1);
    chk("add_wb", 32'(wb_snap), 32'b1100);

    run_instr(OP_LW, 3, -1, -1);
    chk("lw_states", st_pack, 32'o01233334);
    chk("lw_mrd_cycles", 32'(mrd_cnt), 32'd4);
    chk("lw_wb", 32'(wb_snap), 32'b1011);

    run_instr(OP_BEQ, 0, 1, -1);
    chk("beq_taken_states", st_pack, 32'o015);
    chk("beq_taken_pcsrc", 32'(last_pcsrc), 32'b01);
    run_instr(OP_BEQ, 0, 0, -1);
    chk("beq_not_taken_pcsrc", 32'(last_pcsrc), 32'b00);

    run_instr(OP_JAL, 0, -1, -1);
    chk("jal_states", st_pack, 32'o01);
    chk("jal_id", 32'(id_snap), 32'b1100011);
    run_instr(OP_JR, 0, -1, -1);
    chk("jr_id", 32'(id_snap), 32'b1000010);

    run_instr(OP_SW, 2, -1, -1);
    chk("sw_states", st_pack, 32'o012333);
    chk("sw_pcwre_pulses", 32'(pc_cnt), 32'd1);

    run_instr(OP_ADD, 0, -1, 3);
    run_instr(OP_ADD, 0, -1, -1);
    chk("after_abort_states", st_pack, 32'o0167);

    for (int n = 0; n < 300; n++) begin
      rop = pick_op();
      run_instr(rop, $urandom_range(0, 3), -1,
                ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 5)) : -1);
    end

    run_instr(OP_HALT, 0, -1, -1);
    chk("halt_pcwre", 32'(pc_cnt), 32'd0);
    chk("halted_set", 32'(halted), 32'd1);
    hold = 0;
    for (int n = 0; n < 12; n++) begin
      rop = pick_op();
      run_instr(rop, 0, -1, -1);
      hold += hold_cnt;
    end
    chk("halted_hold", 32'(hold), 32'd0);
    chk("halted_sticky", 32'(halted), 32'd1);

    exp_valid = 1'b0;
    Reset     = 1'b1;
    #1;
    chk("halt_cleared", 32'(halted), 32'd0);
    m_halted = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    run_instr(OP_ADD, 0, -1, -1);
    chk("post_halt_add", st_pack, 32'o0167);

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
